vga_timing_gen: RTL and testbench

- Downstream consumer of the 100 MHz board clock in the PiCamera design.
- Generates a 25 MHz pixel strobe and 640x480@60 VGA timing: hsync, vsync, active-area pixel coordinates and a frame-start pulse.
- Drives the registered 8-bit rgb to the VGA connector, blanked outside the active area.
- Replaces free-running clock division: everything runs on clk_in with a clock-enable, with no derived clocks.

---
 rtl/vga_pkg.sv | 35 +++
 rtl/vga_sync_delay.sv | 36 +++
 rtl/vga_timing_gen.sv | 121 ++++++++++++
 tb/tb_vga_timing_gen.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync/active bundle type and idle values.
package vga_pkg;

   localparam int unsigned COORD_W = 10;

   localparam int unsigned CE_DIV  = 4;
   localparam int unsigned PIX_LAT = 2;

   localparam int unsigned H_ACTIVE = 640;
   localparam int unsigned H_FP     = 16;
   localparam int unsigned H_SYNC   = 96;
   localparam int unsigned H_BP     = 48;
   localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

   localparam int unsigned V_ACTIVE = 480;
   localparam int unsigned V_FP     = 10;
   localparam int unsigned V_SYNC   = 2;
   localparam int unsigned V_BP     = 33;
   localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

   typedef struct packed {
      logic hs;
      logic vs;
      logic active;
   } sync_t;

   localparam sync_t      SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};
   localparam logic [7:0] RGB_IDLE  = 8'h00;

endpackage

// File: rtl/vga_sync_delay.sv
// Clock-enabled shift register with async reset and synchronous flush to RST_VAL.
module vga_sync_delay #(
   parameter int unsigned      WIDTH   = 3,
   parameter int unsigned      DEPTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk_in,
   input  logic             rst_n,
   input  logic             ce,
   input  logic             flush,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = ^{clk_in, rst_n, ce, flush};
      assign dout        = din;
   end else begin : g_shift
      logic [WIDTH-1:0] stage_q [DEPTH];

      always_ff @(posedge clk_in or negedge rst_n) begin
         if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
         end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stage_q[i] <= RST_VAL;
         end else if (ce) begin
            stage_q[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
         end
      end

      assign dout = stage_q[DEPTH-1];
   end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing on clk_in with a pixel clock-enable; syncs and rgb aligned to a PIX_LAT source.
module vga_timing_gen #(
   parameter int unsigned CE_DIV   = vga_pkg::CE_DIV,
   parameter int unsigned PIX_LAT  = vga_pkg::PIX_LAT,
   parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
   parameter int unsigned H_FP     = vga_pkg::H_FP,
   parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
   parameter int unsigned H_BP     = vga_pkg::H_BP,
   parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
   parameter int unsigned V_FP     = vga_pkg::V_FP,
   parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
   parameter int unsigned V_BP     = vga_pkg::V_BP
) (
   input  logic                        clk_in,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic [7:0]                  rgb_in,
   output logic                        pix_ce,
   output logic [vga_pkg::COORD_W-1:0] pix_x,
   output logic [vga_pkg::COORD_W-1:0] pix_y,
   output logic                        pix_req,
   output logic                        frame_start,
   output logic [7:0]                  rgb,
   output logic                        hsync,
   output logic                        vsync
);
   import vga_pkg::*;

   localparam int unsigned CE_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

   localparam logic [CE_W-1:0]    CE_LAST  = CE_W'(CE_DIV - 1);
   localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
   localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
   localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_ACTIVE + H_FP);
   localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_ACTIVE + V_FP);
   localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CE_W-1:0]    ce_q, ce_d;
   logic [COORD_W-1:0] h_q, h_d;
   logic [COORD_W-1:0] v_q, v_d;
   sync_t              raw, dly;

   assign pix_ce      = enable && (ce_q == CE_LAST);
   assign pix_x       = h_q;
   assign pix_y       = v_q;
   assign frame_start = pix_ce && (h_q == '0) && (v_q == '0);
   assign pix_req     = raw.active;

   always_comb begin
      ce_d = (ce_q == CE_LAST) ? '0 : ce_q + CE_W'(1);
      h_d  = h_q;
      v_d  = v_q;
      if (pix_ce) begin
         if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + COORD_W'(1);
         end else begin
            h_d = h_q + COORD_W'(1);
         end
      end
      // Disable restarts the raster from (0,0) on the next edge.
      if (!enable) begin
         ce_d = '0;
         h_d  = '0;
         v_d  = '0;
      end
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         ce_q <= '0;
         h_q  <= '0;
         v_q  <= '0;
      end else begin
         ce_q <= ce_d;
         h_q  <= h_d;
         v_q  <= v_d;
      end
   end

   always_comb begin
      raw        = SYNC_IDLE;
      raw.active = (h_q < H_ACT) && (v_q < V_ACT);
      raw.hs     = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
      raw.vs     = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
   end

   // PIX_LAT-1 stages plus the output register give PIX_LAT pixels of total latency.
   vga_sync_delay #(
      .WIDTH   ($bits(sync_t)),
      .DEPTH   (PIX_LAT - 1),
      .RST_VAL (SYNC_IDLE)
   ) u_sync_delay (
      .clk_in (clk_in),
      .rst_n  (rst_n),
      .ce     (pix_ce),
      .flush  (!enable),
      .din    (raw),
      .dout   (dly)
   );

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         rgb   <= RGB_IDLE;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (!enable) begin
         rgb   <= RGB_IDLE;
         hsync <= 1'b1;
         vsync <= 1'b1;
      end else if (pix_ce) begin
         rgb   <= dly.active ? rgb_in : RGB_IDLE;
         hsync <= dly.hs;
         vsync <= dly.vs;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized bench: full-size and reduced-geometry instances checked every cycle against a raster model.
module tb_vga_timing_gen;

   localparam int CE = 4;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, lat, salt;
   } geom_t;

   typedef struct {
      bit ce, fs, req, hs, vs;
      int x, y, rgb;
   } exp_t;

   logic       clk_in = 1'b0;
   logic       rst_n, enable;
   logic [7:0] rgb_in_b, rgb_in_s;

   logic       pix_ce_b, pix_req_b, frame_start_b, hsync_b, vsync_b;
   logic [9:0] pix_x_b, pix_y_b;
   logic [7:0] rgb_b;
   logic       pix_ce_s, pix_req_s, frame_start_s, hsync_s, vsync_s;
   logic [9:0] pix_x_s, pix_y_s;
   logic [7:0] rgb_s;

   always #5 clk_in = ~clk_in;

   vga_timing_gen u_dut_big (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .enable      (enable),
      .rgb_in      (rgb_in_b),
      .pix_ce      (pix_ce_b),
      .pix_x       (pix_x_b),
      .pix_y       (pix_y_b),
      .pix_req     (pix_req_b),
      .frame_start (frame_start_b),
      .rgb         (rgb_b),
      .hsync       (hsync_b),
      .vsync       (vsync_b)
   );

   vga_timing_gen #(
      .CE_DIV   (4),
      .PIX_LAT  (3),
      .H_ACTIVE (16),
      .H_FP     (4),
      .H_SYNC   (6),
      .H_BP     (4),
      .V_ACTIVE (8),
      .V_FP     (2),
      .V_SYNC   (2),
      .V_BP     (3)
   ) u_dut_small (
      .clk_in      (clk_in),
      .rst_n       (rst_n),
      .enable      (enable),
      .rgb_in      (rgb_in_s),
      .pix_ce      (pix_ce_s),
      .pix_x       (pix_x_s),
      .pix_y       (pix_y_s),
      .pix_req     (pix_req_s),
      .frame_start (frame_start_s),
      .rgb         (rgb_s),
      .hsync       (hsync_s),
      .vsync       (vsync_s)
   );

   int     checks = 0;
   int     errors = 0;
   longint t = 0;
   geom_t  gb, gs;
   logic   rst_req, en_req;
   bit     mon_on = 0, re_on = 0;
   logic   prev_hs_b = 1'b1, prev_vs_s = 1'b1;
   longint hs_fall = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
   longint fs1 = -1, fs2 = -1, fs_re = -1;

   function automatic int ht(geom_t g);
      return g.ha + g.hf + g.hs + g.hb;
   endfunction

   function automatic int vt(geom_t g);
      return g.va + g.vf + g.vs + g.vb;
   endfunction

   function automatic int px(geom_t g, longint p);
      return int'(p % ht(g));
   endfunction

   function automatic int py(geom_t g, longint p);
      return int'((p / ht(g)) % vt(g));
   endfunction

   function automatic bit is_active(geom_t g, longint p);
      return (px(g, p) < g.ha) && (py(g, p) < g.va);
   endfunction

   function automatic int color(geom_t g, longint p);
      return (px(g, p) + py(g, p) * g.salt) & 255;
   endfunction

   // Upstream source with PIX_LAT-1 pixels of latency; junk (often FF) while blanking.
   function automatic logic [7:0] src(geom_t g, longint tt);
      longint k;
      k = tt / CE - (g.lat - 1);
      if (k >= 0 && is_active(g, k)) return 8'(color(g, k));
      if ($urandom_range(0, 1) == 1) return 8'hFF;
      return 8'($urandom);
   endfunction

   // Expected outputs after tt enabled cycles since the last restart.
   function automatic exp_t model(geom_t g, longint tt, bit en);
      exp_t   e;
      longint p, q;
      int     qx, qy;
      p     = tt / CE;
      e.x   = px(g, p);
      e.y   = py(g, p);
      e.ce  = en && (tt % CE == CE - 1);
      e.req = (e.x < g.ha) && (e.y < g.va);
      e.fs  = e.ce && (e.x == 0) && (e.y == 0);
      q     = p - g.lat;
      if (q < 0) begin
         e.hs  = 1'b1;
         e.vs  = 1'b1;
         e.rgb = 0;
      end else begin
         qx    = px(g, q);
         qy    = py(g, q);
         e.hs  = !(qx >= g.ha + g.hf && qx < g.ha + g.hf + g.hs);
         e.vs  = !(qy >= g.va + g.vf && qy < g.va + g.vf + g.vs);
         e.rgb = is_active(g, q) ? color(g, q) : 0;
      end
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0d", name, act, exp, t);
      end
   endtask

   task automatic cmp(input string tag, input geom_t g, input logic ce, input logic fs,
                      input logic req, input logic hs, input logic vs, input logic [9:0] x,
                      input logic [9:0] y, input logic [7:0] rgb);
      exp_t e;
      e = model(g, t, enable);
      check({tag, ".pix_ce"}, 32'(ce), 32'(e.ce));
      check({tag, ".frame_start"}, 32'(fs), 32'(e.fs));
      check({tag, ".pix_req"}, 32'(req), 32'(e.req));
      check({tag, ".hsync"}, 32'(hs), 32'(e.hs));
      check({tag, ".vsync"}, 32'(vs), 32'(e.vs));
      check({tag, ".pix_x"}, 32'(x), e.x);
      check({tag, ".pix_y"}, 32'(y), e.y);
      check({tag, ".rgb"}, 32'(rgb), e.rgb);
   endtask

   task automatic compare_all();
      cmp("big", gb, pix_ce_b, frame_start_b, pix_req_b, hsync_b, vsync_b, pix_x_b, pix_y_b,
          rgb_b);
      cmp("small", gs, pix_ce_s, frame_start_s, pix_req_s, hsync_s, vsync_s, pix_x_s, pix_y_s,
          rgb_s);
   endtask

   task automatic monitor();
      if (mon_on) begin
         if (prev_hs_b && !hsync_b && hs_fall < 0) hs_fall = t;
         if (!prev_hs_b && hsync_b && hs_fall >= 0 && hs_rise < 0) hs_rise = t;
         if (prev_vs_s && !vsync_s && vs_fall < 0) vs_fall = t;
         if (!prev_vs_s && vsync_s && vs_fall >= 0 && vs_rise < 0) vs_rise = t;
         if (frame_start_s) begin
            if (fs1 < 0) fs1 = t;
            else if (fs2 < 0) fs2 = t;
         end
      end
      if (re_on && frame_start_s && fs_re < 0) fs_re = t;
      prev_hs_b = hsync_b;
      prev_vs_s = vsync_s;
   endtask

   task automatic cycle();
      @(posedge clk_in);
      if (!rst_n || !enable) t = 0;
      else t = t + 1;
      #1;
      rst_n    = rst_req;
      enable   = en_req;
      rgb_in_b = src(gb, t);
      rgb_in_s = src(gs, t);
      @(negedge clk_in);
      compare_all();
      monitor();
   endtask

   initial begin
      gb = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 0};
      gs = '{16, 4, 6, 4, 8, 2, 2, 3, 3, int'($urandom_range(1, 255))};
      rst_n    = 1'b0;
      enable   = 1'b0;
      rst_req  = 1'b0;
      en_req   = 1'b0;
      rgb_in_b = 8'h00;
      rgb_in_s = 8'h00;

      repeat (4) cycle();
      check("reset.rgb", 32'(rgb_b), 0);
      check("reset.hsync", 32'(hsync_b), 1);
      check("reset.vsync", 32'(vsync_s), 1);

      // Free run from (0,0): line and frame timing.
      rst_req = 1'b1;
      en_req  = 1'b1;
      mon_on  = 1;
      repeat (4000) cycle();
      mon_on = 0;
      check("hsync_fall_t", 32'(hs_fall), 2632);
      check("hsync_low_cycles", 32'(hs_rise - hs_fall), 384);
      check("vsync_fall_t", 32'(vs_fall), 1212);
      check("vsync_low_cycles", 32'(vs_rise - vs_fall), 240);
      check("frame_start_first_t", 32'(fs1), 3);
      check("frame_start_period", 32'(fs2 - fs1), 1800);

      // Mid-frame disable, hold, re-enable.
      repeat ($urandom_range(200, 1500)) cycle();
      en_req = 1'b0;
      cycle();
      cycle();
      check("disable.pix_x", 32'(pix_x_s), 0);
      check("disable.pix_y", 32'(pix_y_s), 0);
      check("disable.rgb", 32'(rgb_s), 0);
      check("disable.hsync", 32'(hsync_b), 1);
      check("disable.vsync", 32'(vsync_s), 1);
      repeat (8) cycle();
      en_req = 1'b1;
      fs_re  = -1;
      re_on  = 1;
      repeat (20) cycle();
      re_on = 0;
      check("reenable.frame_start_t", 32'(fs_re), 3);

      // Random short enable drops.
      for (int i = 0; i < 8; i++) begin
         repeat ($urandom_range(30, 600)) cycle();
         en_req = 1'b0;
         repeat ($urandom_range(1, 5)) cycle();
         en_req = 1'b1;
      end

      // Asynchronous reset between clock edges.
      repeat ($urandom_range(100, 300)) cycle();
      #2;
      rst_n   = 1'b0;
      rst_req = 1'b0;
      t       = 0;
      #1;
      compare_all();
      check("async_rst.rgb", 32'(rgb_s), 0);
      check("async_rst.hsync", 32'(hsync_b), 1);
      check("async_rst.vsync", 32'(vsync_s), 1);
      repeat (3) cycle();
      rst_req = 1'b1;
      fs_re   = -1;
      re_on   = 1;
      repeat (20) cycle();
      re_on = 0;
      check("post_rst.frame_start_t", 32'(fs_re), 3);
      repeat (2000) cycle();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
